// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the full-subtractor borrow equation.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Borrow out of one full-subtractor bit computing x - y - bin.
    function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

endpackage

// File: rtl/fs_df.sv
// Purely combinational dataflow full subtractor: d = x - y - bin, bout = borrow out.
module fs_df
    import serial_sub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = fs_borrow(x, y, bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor, diff = a - b, LSB first through one full
// subtractor and a registered borrow. start/ready/done handshake; one
// operation every N+2 cycles, all outputs registered.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow,
    output logic         ovf
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   a_sr;
    logic [N-1:0]   b_sr;
    logic [N-1:0]   d_sr;
    logic           brw;
    logic           a_msb;
    logic           b_msb;
    logic           bit_d;
    logic           bit_bout;

    // The single bit-slice: current LSBs of the operand shifters plus the running borrow.
    fs_df u_fs (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (brw),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Control FSM, bit counter, shift registers and registered result outputs.
    // NOTE: every register here uses <= so all flops update from the same
    // pre-edge values; a blocking = would let later lines see half-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            brw    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ready  <= 1'b1;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        a_msb <= a[N-1];
                        b_msb <= b[N-1];
                        brw   <= 1'b0;
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    d_sr <= {bit_d, d_sr[N-1:1]};
                    a_sr <= {1'b0, a_sr[N-1:1]};
                    b_sr <= {1'b0, b_sr[N-1:1]};
                    brw  <= bit_bout;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        // The bit just computed is the result MSB, so publish
                        // the full result on this edge.
                        diff   <= {bit_d, d_sr[N-1:1]};
                        borrow <= bit_bout;
                        ovf    <= (a_msb ^ b_msb) & (bit_d ^ a_msb);
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (N=8): table-driven vectors through a
// result scoreboard, plus back-to-back issue, mid-run reset and reset/start
// collision sequences.
module tb_serial_sub;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         ready;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow;
    logic         ovf;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] diff;
        logic         borrow;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [N-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_seen = 0;

    serial_sub #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard side: compare each done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("diff", 32'(diff), 32'(e.diff));
                check("borrow", 32'(borrow), 32'(e.borrow));
                check("ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y);
        exp_t e;
        e.diff   = x - y;
        e.borrow = (x < y);
        e.ovf    = (x[N-1] != y[N-1]) && (e.diff[N-1] != x[N-1]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and measure edges from accept to done.
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input exp_t e, input string tag);
        int waited = 0;
        int lat = 0;
        while (ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_ready_timeout"}, 32'(ready), 32'd1);
        a = x;
        b = y;
        start = 1'b1;
        sb.push_back(e);
        tick();
        start = 1'b0;
        a = 8'h5A;
        b = 8'hC3;
        check({tag, "_ready_low"}, 32'(ready), 32'd0);
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(N));
    endtask

    initial begin
        int d0;
        exp_t ff_exp;

        vecs[0] = '{a: 8'd100, b: 8'd37, diff: 8'd63, borrow: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'd5,   b: 8'd9,  diff: 8'hFC, borrow: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h80,  b: 8'h01, diff: 8'h7F, borrow: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'h7F,  b: 8'hFF, diff: 8'h80, borrow: 1'b1, ovf: 1'b1};
        vecs[4] = '{a: 8'h00,  b: 8'h01, diff: 8'hFF, borrow: 1'b1, ovf: 1'b0};
        vecs[5] = '{a: 8'h80,  b: 8'h7F, diff: 8'h01, borrow: 1'b0, ovf: 1'b1};
        vecs[6] = '{a: 8'hFF,  b: 8'h00, diff: 8'hFF, borrow: 1'b0, ovf: 1'b0};
        vecs[7] = '{a: 8'h00,  b: 8'h80, diff: 8'h80, borrow: 1'b1, ovf: 1'b1};
        vecs[8] = '{a: 8'h55,  b: 8'h55, diff: 8'h00, borrow: 1'b0, ovf: 1'b0};

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            exp_t e;
            e.diff   = vecs[i].diff;
            e.borrow = vecs[i].borrow;
            e.ovf    = vecs[i].ovf;
            run_op(vecs[i].a, vecs[i].b, e, $sformatf("vec%0d", i));
        end

        // Random vectors against the arithmetic model.
        for (int i = 0; i < 6; i++) begin
            logic [N-1:0] x;
            logic [N-1:0] y;
            x = N'($urandom);
            y = N'($urandom);
            run_op(x, y, model(x, y), $sformatf("rnd%0d", i));
        end

        // start held high for 30 edges: accepts on edges 0, 10, 20; operands
        // are scrambled between accepts and must not matter.
        while (ready !== 1'b1) tick();
        ff_exp = '{diff: 8'h00, borrow: 1'b0, ovf: 1'b0};
        d0 = done_seen;
        start = 1'b1;
        for (int t = 0; t < 30; t++) begin
            check($sformatf("held_ready_t%0d", t), 32'(ready), 32'(t % 10 == 0));
            if (t % 10 == 0) begin
                a = 8'hFF;
                b = 8'hFF;
                sb.push_back(ff_exp);
            end else begin
                a = N'($urandom);
                b = N'($urandom);
            end
            tick();
        end
        start = 1'b0;
        check("held_done_count", 32'(done_seen - d0), 32'd3);

        // Reset on the 4th RUN edge aborts the operation and clears outputs.
        while (ready !== 1'b1) tick();
        a = 8'd100;
        b = 8'd37;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_borrow", 32'(borrow), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        d0 = done_seen;
        for (int t = 0; t < 12; t++) tick();
        check("midrst_no_done", 32'(done_seen - d0), 32'd0);
        run_op(8'd100, 8'd37, model(8'd100, 8'd37), "after_rst");

        // rst and start together: stays idle, no done.
        while (ready !== 1'b1) tick();
        d0 = done_seen;
        a = 8'h12;
        b = 8'h34;
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("rst_start_ready", 32'(ready), 32'd1);
        for (int t = 0; t < 12; t++) tick();
        check("rst_start_no_done", 32'(done_seen - d0), 32'd0);
        check("rst_start_idle_ready", 32'(ready), 32'd1);

        tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial N-bit subtractor computing diff = a − b one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It complements the team's combinational full-adder datapath: it is the subtract direction, built area-lean for control paths where latency is cheap and gates are not. It uses a start/ready/done handshake so a sequencer can issue operations back to back.

## Interface
- N, 8, operand/result width in bits; legal range N ≥ 2
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset, sampled on clk rising edge
- start  input  1  request; sampled only while ready=1
- a  input  N  minuend, captured on the accepting edge
- b  input  N  subtrahend, captured on the accepting edge
- ready  output  1  block idle, will accept start
- done  output  1  one-cycle pulse: diff/borrow/ovf valid
- diff  output  N  (a − b) mod 2^N
- borrow  output  1  1 when a < b unsigned
- ovf  output  1  signed two's-complement overflow of a − b

## Operation
- States: IDLE (ready=1), RUN (N bit-steps), DONE (done=1 for one cycle).
- IDLE: start=1 at an edge → capture a, b into shift registers, clear borrow flop, clear bit counter, go to RUN. start=0 → stay.
- RUN, each edge: x=a_sr[0], y=b_sr[0], bin=borrow flop; d=x^y^bin; bout=(~x&y)|(~(x^y)&bin); shift d into diff_sr MSB end, shift a_sr/b_sr right, borrow flop←bout, counter+1. After the Nth step go to DONE.
- Sign capture: MSB of a and b are held from load for ovf; ovf = (a[N-1]≠b[N-1]) & (diff[N-1]≠a[N-1]).
- DONE: done=1, ready=0; diff, borrow, ovf registered and valid. Next edge → IDLE.
- Outputs diff/borrow/ovf hold their last values until the next DONE; they may change only on the edge entering DONE.
- start while ready=0 (RUN or DONE) is ignored, not queued.
- Reset: rst=1 at any edge, including mid-RUN → IDLE; ready=1, done=0, diff=0, borrow=0, ovf=0, counter and shift registers 0. rst dominates start in the same cycle.
- Counter width $clog2(N+1); no wrap occurs because RUN exits at count N−1.

## Timing
- Accepting edge k (ready=1, start=1): ready falls after edge k.
- Bit i processed on edge k+1+i, i=0..N−1.
- done=1 in the cycle after edge k+N; ready=1 again after edge k+N+1.
- Latency start-accept to done: N+1 cycles; issue interval: N+2 cycles (start may be held high continuously; next accept occurs on edge k+N+2).
- No combinational path from inputs to outputs.

## Structure
- Shared package serial_sub_pkg: state encoding localparams/typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2), full-subtractor borrow function if the team's flow permits.
- One sub-module: fs_df, a purely combinational dataflow full subtractor (ports d, bout, x, y, bin), instantiated once in the RUN datapath.
- Top holds FSM, counter, three shift registers, borrow flop, sign flops.

## Test plan
- N=8, a=100, b=37, start one cycle → done exactly 9 cycles after accept; diff=63, borrow=0, ovf=0.
- a=5, b=9 → diff=8'hFC, borrow=1, ovf=0.
- a=8'h80, b=8'h01 → diff=8'h7F, borrow=0, ovf=1; a=8'h7F, b=8'hFF → diff=8'h80, borrow=1, ovf=1.
- start held high for 30 cycles with a=b=8'hFF → accepts every 10 cycles, each done with diff=0, borrow=0, ovf=0; mid-run changes to a/b have no effect.
- rst pulsed on the 4th RUN cycle → next cycle ready=1, done=0, diff=0, borrow=0, ovf=0; new start then yields correct result in 9 cycles.
- rst and start both high at an edge → stays IDLE, no done.
